// File: rtl/gaussian_pkg.sv
// Shared types and constants for the gaussian accelerator datapath.
package gaussian_pkg;

   // Default output buffer depth (512-bit lines) of the flow controller.
   localparam int unsigned HC_FLOW_FIFO_DEPTH = 64;

   // One CCI-P cache line.
   typedef logic [511:0] t_hc_line;

   // Job sequencing states of the flow controller.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } t_flow_state;

endpackage : gaussian_pkg

// File: rtl/hc_sync_fifo.sv
// Single-clock show-ahead FIFO: the head entry is presented on data_o while
// empty_o is low. Pushes while full are dropped unless a pop happens in the
// same cycle. Pops while empty are ignored.
module hc_sync_fifo
   import gaussian_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 512
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         data_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == DEPTH_C);
   assign count_o = count_q;
   assign data_o  = mem_q[rd_ptr_q];

   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   // Pointer and occupancy next-state; pointers wrap naturally (DEPTH is a power of two).
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      if (do_push && !do_pop) begin
         count_d = count_q + CNT_ONE;
      end else if (!do_push && do_pop) begin
         count_d = count_q - CNT_ONE;
      end
   end

   // Pointer and occupancy registers; reset empties the buffer.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage write; contents need no reset because occupancy gates visibility.
   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

endmodule : hc_sync_fifo

// File: rtl/gaussian_flow_ctrl.sv
// Credit-based flow controller between gaussian_requestor and the
// fixed-latency gaussian pipeline. Outstanding reads are limited to the
// output buffer depth so the pipeline, which cannot be stalled, never
// overflows the buffer. Sequences one job from start to done.
module gaussian_flow_ctrl
   import gaussian_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = HC_FLOW_FIFO_DEPTH,
   parameter int unsigned CNT_W      = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [CNT_W-1:0]  num_lines,
   output logic              rd_issue_ok,
   input  logic              rd_issued,
   input  logic              pipe_valid,
   input  logic [511:0]      pipe_data,
   output logic              wr_valid,
   output logic [511:0]      wr_data,
   input  logic              wr_ready,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  lines_written,
   output logic              err_overflow
);

   localparam int unsigned     IW      = $clog2(FIFO_DEPTH) + 1;
   localparam logic [IW-1:0]   DEPTH_C = IW'(FIFO_DEPTH);
   localparam logic [IW-1:0]   IF_ONE  = IW'(1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   t_flow_state      state_q, state_d;
   logic [CNT_W-1:0] num_lines_q, num_lines_d;
   logic [CNT_W-1:0] issued_q, issued_d;
   logic [CNT_W-1:0] lines_written_q, lines_written_d;
   logic [IW-1:0]    inflight_q, inflight_d;
   logic             err_overflow_q, err_overflow_d;

   logic             fifo_full, fifo_empty;
   logic [IW-1:0]    fifo_count;
   t_hc_line         fifo_head;

   logic             rd_accept;
   logic             pop;
   logic             start_ok;
   logic             job_active;

   hc_sync_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH ($bits(t_hc_line))
   ) u_fifo (
      .clk_i   (clk),
      .reset_i (reset),
      .push_i  (pipe_valid),
      .data_i  (pipe_data),
      .pop_i   (pop),
      .data_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   assign job_active  = (state_q == RUN) || (state_q == DRAIN);
   assign rd_issue_ok = (state_q == RUN) && (issued_q < num_lines_q) &&
                        (inflight_q < DEPTH_C);
   assign rd_accept   = rd_issued && rd_issue_ok;
   assign wr_valid    = !fifo_empty;
   assign wr_data     = fifo_empty ? '0 : fifo_head;
   assign pop         = wr_valid && wr_ready;
   assign start_ok    = start && ((state_q == IDLE) || (state_q == DONE));

   assign busy          = job_active;
   assign done          = (state_q == DONE);
   assign lines_written = lines_written_q;
   assign err_overflow  = err_overflow_q;

   // Job counters, credit tracking and sticky overflow flag.
   always_comb begin
      num_lines_d     = num_lines_q;
      issued_d        = issued_q;
      lines_written_d = lines_written_q;
      inflight_d      = inflight_q;
      err_overflow_d  = err_overflow_q | (pipe_valid && fifo_full && !pop);

      if (rd_accept) begin
         issued_d = issued_q + CNT_ONE;
      end
      // Floor at zero: lines left over from an aborted job may still drain.
      if (rd_accept && !pop) begin
         inflight_d = inflight_q + IF_ONE;
      end else if (!rd_accept && pop && (inflight_q != '0)) begin
         inflight_d = inflight_q - IF_ONE;
      end
      if (pop && job_active) begin
         lines_written_d = lines_written_q + CNT_ONE;
      end

      if (start_ok) begin
         num_lines_d     = num_lines;
         issued_d        = '0;
         inflight_d      = '0;
         lines_written_d = '0;
      end
   end

   // Job sequencing next-state.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = (num_lines == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (issued_d == num_lines_q) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if ((lines_written_q == num_lines_q) && (fifo_count == '0)) begin
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Counter and flag registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         num_lines_q     <= '0;
         issued_q        <= '0;
         lines_written_q <= '0;
         inflight_q      <= '0;
         err_overflow_q  <= 1'b0;
      end else begin
         num_lines_q     <= num_lines_d;
         issued_q        <= issued_d;
         lines_written_q <= lines_written_d;
         inflight_q      <= inflight_d;
         err_overflow_q  <= err_overflow_d;
      end
   end

endmodule : gaussian_flow_ctrl
